// File: rtl/clock_mode_ctrl_pkg.sv
// Shared definitions for the clock mode controller: command mode encodings,
// command FSM states, default accepted year range and the calendar helper
// used to validate manual set-date requests.
package clock_pkg;

    localparam int unsigned DEF_YEAR_MIN = 2020;
    localparam int unsigned DEF_YEAR_MAX = 2025;

    // Values 0 and 5-7 on cmd_mode are illegal and are rejected.
    typedef enum logic [2:0] {
        MODE_12H   = 3'd1,
        MODE_24H   = 3'd2,
        MODE_SET   = 3'd3,
        MODE_ALARM = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LOAD,
        ST_ERR
    } state_t;

    // Returns 0 for an out-of-range month so any day fails the bound check.
    function automatic logic [4:0] days_in_month(input logic [3:0]  month,
                                                 input logic [11:0] year);
        logic leap;
        leap = (((year % 12'd4) == 12'd0) && ((year % 12'd100) != 12'd0))
               || ((year % 12'd400) == 12'd0);
        case (month)
            4'd2:                         days_in_month = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:      days_in_month = 5'd30;
            4'd1, 4'd3, 4'd5, 4'd7,
            4'd8, 4'd10, 4'd12:           days_in_month = 5'd31;
            default:                      days_in_month = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_alarm_timer.sv
// Countdown alarm: counts seconds down from an armed value, then rings for
// RING_SECS seconds or until acknowledged.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   arm         - one-cycle pulse: (re)start countdown from arm_secs, stop ring
//   arm_secs    - countdown length in seconds (non-zero when arm is pulsed)
//   sec_tick    - one-cycle pulse per elapsed second
//   ack         - silences an active ring; ignored otherwise
//   armed       - countdown in progress
//   ring        - alarm sounding
module alarm_timer #(
    parameter int unsigned RING_SECS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic [15:0] arm_secs,
    input  logic        sec_tick,
    input  logic        ack,
    output logic        armed,
    output logic        ring
);

    localparam int unsigned RING_W = $clog2(RING_SECS + 1);

    logic [15:0]       count;
    logic [RING_W-1:0] ring_cnt;

    // armed and ring are mutually exclusive, so the branches never compete;
    // arm takes priority over a tick arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            ring_cnt <= '0;
            armed    <= 1'b0;
            ring     <= 1'b0;
        end else if (arm) begin
            count    <= arm_secs;
            ring_cnt <= '0;
            armed    <= 1'b1;
            ring     <= 1'b0;
        end else if (armed) begin
            if (sec_tick) begin
                if (count == 16'd1) begin
                    count    <= '0;
                    armed    <= 1'b0;
                    ring     <= 1'b1;
                    ring_cnt <= RING_W'(RING_SECS);
                end else begin
                    count <= count - 16'd1;
                end
            end
        end else if (ring) begin
            if (ack) begin
                ring     <= 1'b0;
                ring_cnt <= '0;
            end else if (sec_tick) begin
                if (ring_cnt == RING_W'(1)) begin
                    ring     <= 1'b0;
                    ring_cnt <= '0;
                end else begin
                    ring_cnt <= ring_cnt - RING_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Command-driven controller in front of the timekeeping core. Accepts mode
// commands, validates set-time/date requests and issues a one-cycle load
// strobe with a registered set bus; owns 12/24 h display formatting and the
// minutes-based countdown alarm.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   sec_tick                - one pulse per second from the core
//   cmd_valid / cmd_ready   - command handshake
//   cmd_mode, cmd_*         - command code and payload fields
//   cur_hour                - live hour from the core (0-23)
//   load, set_*             - load strobe and set bus into the core
//   cmd_err                 - one-cycle pulse on a rejected command
//   fmt_12h, disp_hour, pm  - display format and formatted hour
//   alarm_armed, alarm_ring - alarm status; alarm_ack silences the ring
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned YEAR_MIN  = DEF_YEAR_MIN,
    parameter int unsigned YEAR_MAX  = DEF_YEAR_MAX,
    parameter int unsigned RING_SECS = 30,
    parameter int unsigned ALARM_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sec_tick,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_mode,
    input  logic [4:0]         cmd_hour,
    input  logic [5:0]         cmd_min,
    input  logic [5:0]         cmd_sec,
    input  logic [4:0]         cmd_day,
    input  logic [3:0]         cmd_month,
    input  logic [11:0]        cmd_year,
    input  logic [ALARM_W-1:0] cmd_alarm_min,
    input  logic [4:0]         cur_hour,
    output logic               load,
    output logic [4:0]         set_hour,
    output logic [5:0]         set_min,
    output logic [5:0]         set_sec,
    output logic [4:0]         set_day,
    output logic [3:0]         set_month,
    output logic [11:0]        set_year,
    output logic               cmd_err,
    output logic               fmt_12h,
    output logic [4:0]         disp_hour,
    output logic               pm,
    output logic               alarm_armed,
    output logic               alarm_ring,
    input  logic               alarm_ack
);

    state_t state, next_state;

    logic [2:0]         hold_mode;
    logic [4:0]         hold_hour;
    logic [5:0]         hold_min;
    logic [5:0]         hold_sec;
    logic [4:0]         hold_day;
    logic [3:0]         hold_month;
    logic [11:0]        hold_year;
    logic [ALARM_W-1:0] hold_alarm_min;

    logic        capture;
    logic        set_update;
    logic        fmt_set;
    logic        fmt_clr;
    logic        arm;
    logic [15:0] arm_secs;
    logic [4:0]  day_max;
    logic        set_ok;

    always_comb begin
        day_max = days_in_month(hold_month, hold_year);
        set_ok  = (hold_hour < 5'd24) && (hold_min < 6'd60) && (hold_sec < 6'd60)
                  && (hold_month >= 4'd1) && (hold_month <= 4'd12)
                  && (hold_day >= 5'd1) && (hold_day <= day_max)
                  && (hold_year >= 12'(YEAR_MIN)) && (hold_year <= 12'(YEAR_MAX));
    end

    assign arm_secs = 16'(hold_alarm_min) * 16'd60;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        load       = 1'b0;
        cmd_err    = 1'b0;
        capture    = 1'b0;
        set_update = 1'b0;
        fmt_set    = 1'b0;
        fmt_clr    = 1'b0;
        arm        = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    capture    = 1'b1;
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                next_state = ST_IDLE;
                case (hold_mode)
                    MODE_12H: fmt_set = 1'b1;
                    MODE_24H: fmt_clr = 1'b1;
                    MODE_SET: begin
                        if (set_ok) begin
                            set_update = 1'b1;
                            next_state = ST_LOAD;
                        end else begin
                            next_state = ST_ERR;
                        end
                    end
                    MODE_ALARM: begin
                        if (hold_alarm_min == '0) begin
                            next_state = ST_ERR;
                        end else begin
                            arm = 1'b1;
                        end
                    end
                    default: next_state = ST_ERR;
                endcase
            end
            ST_LOAD: begin
                load       = 1'b1;
                next_state = ST_IDLE;
            end
            ST_ERR: begin
                cmd_err    = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_mode      <= '0;
            hold_hour      <= '0;
            hold_min       <= '0;
            hold_sec       <= '0;
            hold_day       <= '0;
            hold_month     <= '0;
            hold_year      <= '0;
            hold_alarm_min <= '0;
        end else if (capture) begin
            hold_mode      <= cmd_mode;
            hold_hour      <= cmd_hour;
            hold_min       <= cmd_min;
            hold_sec       <= cmd_sec;
            hold_day       <= cmd_day;
            hold_month     <= cmd_month;
            hold_year      <= cmd_year;
            hold_alarm_min <= cmd_alarm_min;
        end
    end

    // The set bus is updated on entry to LOAD so it is already valid while
    // load is high, and it holds afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_hour  <= '0;
            set_min   <= '0;
            set_sec   <= '0;
            set_day   <= 5'd1;
            set_month <= 4'd1;
            set_year  <= 12'(YEAR_MIN);
        end else if (set_update) begin
            set_hour  <= hold_hour;
            set_min   <= hold_min;
            set_sec   <= hold_sec;
            set_day   <= hold_day;
            set_month <= hold_month;
            set_year  <= hold_year;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fmt_12h <= 1'b0;
        end else if (fmt_set) begin
            fmt_12h <= 1'b1;
        end else if (fmt_clr) begin
            fmt_12h <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_hour <= '0;
            pm        <= 1'b0;
        end else if (fmt_12h) begin
            if (cur_hour == 5'd0) begin
                disp_hour <= 5'd12;
            end else if (cur_hour > 5'd12) begin
                disp_hour <= cur_hour - 5'd12;
            end else begin
                disp_hour <= cur_hour;
            end
            pm <= (cur_hour >= 5'd12);
        end else begin
            disp_hour <= cur_hour;
            pm        <= 1'b0;
        end
    end

    alarm_timer #(
        .RING_SECS (RING_SECS)
    ) u_alarm_timer (
        .clk      (clk),
        .reset    (reset),
        .arm      (arm),
        .arm_secs (arm_secs),
        .sec_tick (sec_tick),
        .ack      (alarm_ack),
        .armed    (alarm_armed),
        .ring     (alarm_ring)
    );

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus randomized set-date and
// alarm traffic checked against a calendar/deadline model of the controller.
module tb_clock_mode_ctrl;

    localparam int unsigned YMIN  = 2020;
    localparam int unsigned YMAX  = 2025;
    localparam int unsigned RSECS = 30;

    logic        clk;
    logic        reset;
    logic        sec_tick;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_mode;
    logic [4:0]  cmd_hour;
    logic [5:0]  cmd_min;
    logic [5:0]  cmd_sec;
    logic [4:0]  cmd_day;
    logic [3:0]  cmd_month;
    logic [11:0] cmd_year;
    logic [9:0]  cmd_alarm_min;
    logic [4:0]  cur_hour;
    logic        load;
    logic [4:0]  set_hour;
    logic [5:0]  set_min;
    logic [5:0]  set_sec;
    logic [4:0]  set_day;
    logic [3:0]  set_month;
    logic [11:0] set_year;
    logic        cmd_err;
    logic        fmt_12h;
    logic [4:0]  disp_hour;
    logic        pm;
    logic        alarm_armed;
    logic        alarm_ring;
    logic        alarm_ack;

    int assertions = 0;
    int failures   = 0;

    // Expected set bus
    int e_hour, e_min, e_sec, e_day, e_month, e_year;

    clock_mode_ctrl #(
        .YEAR_MIN  (YMIN),
        .YEAR_MAX  (YMAX),
        .RING_SECS (RSECS),
        .ALARM_W   (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sec_tick      (sec_tick),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_hour      (cmd_hour),
        .cmd_min       (cmd_min),
        .cmd_sec       (cmd_sec),
        .cmd_day       (cmd_day),
        .cmd_month     (cmd_month),
        .cmd_year      (cmd_year),
        .cmd_alarm_min (cmd_alarm_min),
        .cur_hour      (cur_hour),
        .load          (load),
        .set_hour      (set_hour),
        .set_min       (set_min),
        .set_sec       (set_sec),
        .set_day       (set_day),
        .set_month     (set_month),
        .set_year      (set_year),
        .cmd_err       (cmd_err),
        .fmt_12h       (fmt_12h),
        .disp_hour     (disp_hour),
        .pm            (pm),
        .alarm_armed   (alarm_armed),
        .alarm_ring    (alarm_ring),
        .alarm_ack     (alarm_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_valid(input int h, input int m, input int s,
                                     input int d, input int mo, input int y);
        int  dim [12];
        int  lim;
        bit  leap;
        dim = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (h >= 24 || m >= 60 || s >= 60) return 1'b0;
        if (mo < 1 || mo > 12) return 1'b0;
        if (y < int'(YMIN) || y > int'(YMAX)) return 1'b0;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        lim  = dim[mo-1] + ((mo == 2 && leap) ? 1 : 0);
        return (d >= 1 && d <= lim);
    endfunction

    function automatic logic [37:0] exp_bus();
        return {5'(e_hour), 6'(e_min), 6'(e_sec), 5'(e_day), 4'(e_month), 12'(e_year)};
    endfunction

    // Issues one command and records load/cmd_err/cmd_ready for the four
    // cycles after acceptance (bit 0 = first cycle after the accept edge).
    task automatic send_cmd(input int mode, input int h, input int m, input int s,
                            input int d, input int mo, input int y, input int am,
                            input bit tick_in_check,
                            output logic [3:0] ld, output logic [3:0] er,
                            output logic [3:0] rd);
        int guard;
        guard = 0;
        ld = '0;
        er = '0;
        rd = '0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        assertions++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_wait actual=%b required=1", cmd_ready);
        end
        cmd_valid     = 1'b1;
        cmd_mode      = 3'(mode);
        cmd_hour      = 5'(h);
        cmd_min       = 6'(m);
        cmd_sec       = 6'(s);
        cmd_day       = 5'(d);
        cmd_month     = 4'(mo);
        cmd_year      = 12'(y);
        cmd_alarm_min = 10'(am);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld[i] = load;
            er[i] = cmd_err;
            rd[i] = cmd_ready;
            sec_tick = (i == 0) && tick_in_check;
            tick();
            sec_tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        e_hour = 0; e_min = 0; e_sec = 0; e_day = 1; e_month = 1; e_year = int'(YMIN);
        assertions++;
        if ({fmt_12h, load, cmd_err, alarm_armed, alarm_ring, pm} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=000000",
                     {fmt_12h, load, cmd_err, alarm_armed, alarm_ring, pm});
        end
        assertions++;
        if (disp_hour !== 5'd0) begin
            failures++;
            $display("FAIL reset_disp_hour actual=%0d required=0", disp_hour);
        end
        assertions++;
        if ({set_hour, set_min, set_sec, set_day, set_month, set_year} !== exp_bus()) begin
            failures++;
            $display("FAIL reset_set_bus actual=%h required=%h",
                     {set_hour, set_min, set_sec, set_day, set_month, set_year}, exp_bus());
        end
        reset = 1'b0;
        tick();
        assertions++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready actual=%b required=1", cmd_ready);
        end
    endtask

    task automatic test_set_directed();
        logic [3:0] ld, er, rd;
        send_cmd(3, 23, 59, 58, 29, 2, 2024, 0, 1'b0, ld, er, rd);
        e_hour = 23; e_min = 59; e_sec = 58; e_day = 29; e_month = 2; e_year = 2024;
        assertions++;
        if ({ld, er, rd} !== {4'b0010, 4'b0000, 4'b1100}) begin
            failures++;
            $display("FAIL set_directed_timing load/err/ready actual=%b/%b/%b required=0010/0000/1100",
                     ld, er, rd);
        end
        assertions++;
        if ({set_hour, set_min, set_sec, set_day, set_month, set_year} !== exp_bus()) begin
            failures++;
            $display("FAIL set_directed_bus actual=%h required=%h",
                     {set_hour, set_min, set_sec, set_day, set_month, set_year}, exp_bus());
        end
    endtask

    task automatic test_set_invalid();
        logic [3:0] ld, er, rd;
        int tbl [4][6];
        tbl = '{'{10, 0, 0, 29, 2, 2023}, '{10, 0, 0, 31, 4, 2024},
                '{24, 0, 0, 1, 1, 2024},  '{10, 0, 0, 1, 1, 2026}};
        for (int i = 0; i < 4; i++) begin
            send_cmd(3, tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], tbl[i][5],
                     0, 1'b0, ld, er, rd);
            assertions++;
            if ({ld, er, rd} !== {4'b0000, 4'b0010, 4'b1100}) begin
                failures++;
                $display("FAIL set_invalid_%0d load/err/ready actual=%b/%b/%b required=0000/0010/1100",
                         i, ld, er, rd);
            end
            assertions++;
            if ({set_hour, set_min, set_sec, set_day, set_month, set_year} !== exp_bus()) begin
                failures++;
                $display("FAIL set_invalid_bus_%0d actual=%h required=%h", i,
                         {set_hour, set_min, set_sec, set_day, set_month, set_year}, exp_bus());
            end
        end
    endtask

    task automatic test_set_random();
        logic [3:0] ld, er, rd;
        int h, m, s, d, mo, y;
        bit v;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                h = $urandom_range(0, 31); m = $urandom_range(0, 63); s = $urandom_range(0, 63);
                d = $urandom_range(0, 31); mo = $urandom_range(0, 15); y = $urandom_range(2016, 2030);
            end else begin
                h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
                d = $urandom_range(1, 31); mo = $urandom_range(1, 12); y = $urandom_range(2019, 2026);
            end
            v = ref_valid(h, m, s, d, mo, y);
            send_cmd(3, h, m, s, d, mo, y, 0, 1'b0, ld, er, rd);
            if (v) begin
                e_hour = h; e_min = m; e_sec = s; e_day = d; e_month = mo; e_year = y;
            end
            assertions++;
            if ({ld, er} !== (v ? {4'b0010, 4'b0000} : {4'b0000, 4'b0010})) begin
                failures++;
                $display("FAIL set_random_%0d %0d:%0d:%0d %0d/%0d/%0d load/err actual=%b/%b required_valid=%0d",
                         i, h, m, s, d, mo, y, ld, er, v);
            end
            assertions++;
            if ({set_hour, set_min, set_sec, set_day, set_month, set_year} !== exp_bus()) begin
                failures++;
                $display("FAIL set_random_bus_%0d actual=%h required=%h", i,
                         {set_hour, set_min, set_sec, set_day, set_month, set_year}, exp_bus());
            end
        end
    endtask

    task automatic test_display();
        logic [3:0] ld, er, rd;
        int hours [5];
        int h, eh;
        hours = '{0, 1, 12, 13, 23};
        send_cmd(1, 0, 0, 0, 0, 0, 0, 0, 1'b0, ld, er, rd);
        assertions++;
        if ({fmt_12h, ld, er, rd} !== {1'b1, 4'b0000, 4'b0000, 4'b1110}) begin
            failures++;
            $display("FAIL mode12_cmd fmt/load/err/ready actual=%b/%b/%b/%b required=1/0000/0000/1110",
                     fmt_12h, ld, er, rd);
        end
        for (int i = 0; i < 15; i++) begin
            h = (i < 5) ? hours[i] : int'($urandom_range(0, 23));
            cur_hour = 5'(h);
            tick();
            eh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
            assertions++;
            if ({disp_hour, pm} !== {5'(eh), (h >= 12)}) begin
                failures++;
                $display("FAIL disp12_h%0d disp/pm actual=%0d/%b required=%0d/%b",
                         h, disp_hour, pm, eh, (h >= 12));
            end
        end
        send_cmd(2, 0, 0, 0, 0, 0, 0, 0, 1'b0, ld, er, rd);
        assertions++;
        if ({fmt_12h, rd} !== {1'b0, 4'b1110}) begin
            failures++;
            $display("FAIL mode24_cmd fmt/ready actual=%b/%b required=0/1110", fmt_12h, rd);
        end
        for (int i = 0; i < 6; i++) begin
            h = (i == 0) ? 13 : int'($urandom_range(0, 23));
            cur_hour = 5'(h);
            tick();
            assertions++;
            if ({disp_hour, pm} !== {5'(h), 1'b0}) begin
                failures++;
                $display("FAIL disp24_h%0d disp/pm actual=%0d/%b required=%0d/0",
                         h, disp_hour, pm, h);
            end
        end
    endtask

    task automatic test_alarm_basic();
        logic [3:0] ld, er, rd;
        send_cmd(4, 0, 0, 0, 0, 0, 0, 1, 1'b0, ld, er, rd);
        assertions++;
        if ({alarm_armed, alarm_ring, ld, er, rd} !== {2'b10, 4'b0000, 4'b0000, 4'b1110}) begin
            failures++;
            $display("FAIL alarm_arm armed/ring/load/err/ready actual=%b%b/%b/%b/%b required=10/0000/0000/1110",
                     alarm_armed, alarm_ring, ld, er, rd);
        end
        sec_tick = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            assertions++;
            if ({alarm_armed, alarm_ring} !== {(n < 60), (n == 60)}) begin
                failures++;
                $display("FAIL alarm_countdown_tick%0d armed/ring actual=%b%b required=%b%b",
                         n, alarm_armed, alarm_ring, (n < 60), (n == 60));
            end
        end
        for (int n = 1; n <= 30; n++) begin
            tick();
            assertions++;
            if ({alarm_armed, alarm_ring} !== {1'b0, (n < 30)}) begin
                failures++;
                $display("FAIL alarm_ring_tick%0d armed/ring actual=%b%b required=0%b",
                         n, alarm_armed, alarm_ring, (n < 30));
            end
        end
        sec_tick = 1'b0;
    endtask

    task automatic test_ack();
        logic [3:0] ld, er, rd;
        send_cmd(4, 0, 0, 0, 0, 0, 0, 1, 1'b0, ld, er, rd);
        alarm_ack = 1'b1;
        tick();
        alarm_ack = 1'b0;
        assertions++;
        if ({alarm_armed, alarm_ring} !== 2'b10) begin
            failures++;
            $display("FAIL ack_while_armed armed/ring actual=%b%b required=10", alarm_armed, alarm_ring);
        end
        sec_tick = 1'b1;
        repeat (60) tick();
        assertions++;
        if ({alarm_armed, alarm_ring} !== 2'b01) begin
            failures++;
            $display("FAIL ack_pre_ring armed/ring actual=%b%b required=01", alarm_armed, alarm_ring);
        end
        alarm_ack = 1'b1;
        tick();
        alarm_ack = 1'b0;
        sec_tick  = 1'b0;
        assertions++;
        if ({alarm_armed, alarm_ring} !== 2'b00) begin
            failures++;
            $display("FAIL ack_with_tick armed/ring actual=%b%b required=00", alarm_armed, alarm_ring);
        end
    endtask

    task automatic test_rearm();
        logic [3:0] ld, er, rd;
        send_cmd(4, 0, 0, 0, 0, 0, 0, 1, 1'b0, ld, er, rd);
        sec_tick = 1'b1;
        repeat (30) tick();
        sec_tick = 1'b0;
        // Tick coincides with the re-arm and must not be counted.
        send_cmd(4, 0, 0, 0, 0, 0, 0, 2, 1'b1, ld, er, rd);
        sec_tick = 1'b1;
        for (int n = 1; n <= 120; n++) begin
            tick();
            if (n >= 118) begin
                assertions++;
                if ({alarm_armed, alarm_ring} !== {(n < 120), (n == 120)}) begin
                    failures++;
                    $display("FAIL rearm_tick%0d armed/ring actual=%b%b required=%b%b",
                             n, alarm_armed, alarm_ring, (n < 120), (n == 120));
                end
            end
        end
        sec_tick = 1'b0;
        send_cmd(4, 0, 0, 0, 0, 0, 0, 3, 1'b0, ld, er, rd);
        assertions++;
        if ({alarm_armed, alarm_ring} !== 2'b10) begin
            failures++;
            $display("FAIL rearm_while_ringing armed/ring actual=%b%b required=10",
                     alarm_armed, alarm_ring);
        end
    endtask

    // Deadline model: ring starts once N seconds have elapsed since arming
    // and lasts RSECS seconds unless acknowledged first.
    task automatic test_alarm_random();
        logic [3:0] ld, er, rd;
        int  n_secs, elapsed, ring_left;
        bit  ringing, st, ak, done;
        for (int r = 0; r < 3; r++) begin
            n_secs = 60 * int'($urandom_range(1, 2));
            send_cmd(4, 0, 0, 0, 0, 0, 0, n_secs / 60, 1'b0, ld, er, rd);
            elapsed = 0; ring_left = 0; ringing = 1'b0; done = 1'b0;
            for (int c = 0; c < 2000 && !done; c++) begin
                st = ($urandom_range(0, 1) == 1);
                ak = ($urandom_range(0, 24) == 0);
                sec_tick  = st;
                alarm_ack = ak;
                tick();
                if (elapsed < n_secs) begin
                    if (st) elapsed++;
                    if (elapsed == n_secs) begin
                        ringing   = 1'b1;
                        ring_left = int'(RSECS);
                    end
                end else if (ringing) begin
                    if (ak) ringing = 1'b0;
                    else if (st) begin
                        ring_left--;
                        if (ring_left == 0) ringing = 1'b0;
                    end
                end
                assertions++;
                if ({alarm_armed, alarm_ring} !== {(elapsed < n_secs), ringing}) begin
                    failures++;
                    $display("FAIL alarm_random_r%0d_c%0d armed/ring actual=%b%b required=%b%b",
                             r, c, alarm_armed, alarm_ring, (elapsed < n_secs), ringing);
                end
                done = (elapsed >= n_secs) && !ringing;
            end
            sec_tick  = 1'b0;
            alarm_ack = 1'b0;
        end
    endtask

    task automatic test_errors();
        logic [3:0] ld, er, rd;
        int modes [4];
        int am;
        modes = '{4, 6, 0, 7};
        for (int i = 0; i < 4; i++) begin
            am = (modes[i] == 4) ? 0 : 5;
            send_cmd(modes[i], 1, 1, 1, 1, 1, 2021, am, 1'b0, ld, er, rd);
            assertions++;
            if ({ld, er, rd, alarm_armed} !== {4'b0000, 4'b0010, 4'b1100, 1'b0}) begin
                failures++;
                $display("FAIL err_mode%0d load/err/ready/armed actual=%b/%b/%b/%b required=0000/0010/1100/0",
                         modes[i], ld, er, rd, alarm_armed);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] ld, er, rd;
        int  guard;
        bit  saw_pulse;
        send_cmd(1, 0, 0, 0, 0, 0, 0, 0, 1'b0, ld, er, rd);
        send_cmd(4, 0, 0, 0, 0, 0, 0, 5, 1'b0, ld, er, rd);
        cur_hour = 5'd15;
        tick();
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_mode  = 3'd3; cmd_hour = 5'd7; cmd_min = 6'd8; cmd_sec = 6'd9;
        cmd_day   = 5'd10; cmd_month = 4'd11; cmd_year = 12'd2022;
        tick();
        cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        e_hour = 0; e_min = 0; e_sec = 0; e_day = 1; e_month = 1; e_year = int'(YMIN);
        assertions++;
        if ({fmt_12h, load, cmd_err, alarm_armed, alarm_ring, pm, disp_hour} !== 11'b0) begin
            failures++;
            $display("FAIL reset_abort_outputs fmt/load/err/armed/ring/pm/disp actual=%b%b%b%b%b%b/%0d required=000000/0",
                     fmt_12h, load, cmd_err, alarm_armed, alarm_ring, pm, disp_hour);
        end
        assertions++;
        if ({set_hour, set_min, set_sec, set_day, set_month, set_year} !== exp_bus()) begin
            failures++;
            $display("FAIL reset_abort_bus actual=%h required=%h",
                     {set_hour, set_min, set_sec, set_day, set_month, set_year}, exp_bus());
        end
        tick();
        reset = 1'b0;
        saw_pulse = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (load === 1'b1 || cmd_err === 1'b1) saw_pulse = 1'b1;
        end
        assertions++;
        if ({saw_pulse, alarm_armed, cmd_ready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_abort_after pulse/armed/ready actual=%b%b%b required=001",
                     saw_pulse, alarm_armed, cmd_ready);
        end
    endtask

    initial begin
        reset         = 1'b1;
        sec_tick      = 1'b0;
        cmd_valid     = 1'b0;
        cmd_mode      = '0;
        cmd_hour      = '0;
        cmd_min       = '0;
        cmd_sec       = '0;
        cmd_day       = '0;
        cmd_month     = '0;
        cmd_year      = '0;
        cmd_alarm_min = '0;
        cur_hour      = '0;
        alarm_ack     = 1'b0;

        test_reset();
        test_set_directed();
        test_set_invalid();
        test_set_random();
        test_display();
        test_alarm_basic();
        test_ack();
        test_rearm();
        test_alarm_random();
        test_errors();
        test_reset_abort();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Command-driven controller that sequences the timekeeping core: accepts mode commands, validates manual set-time/date requests, and drives a one-cycle load strobe plus set bus into the core.
- Owns display-format selection (12 h / 24 h) and a minutes-based countdown alarm.
- Sits between the host command decoder and the timekeeping core.

Parameters:
- YEAR_MIN, 2020, lowest accepted year in a set command.
- YEAR_MAX, 2025, highest accepted year in a set command.
- RING_SECS, 30, seconds alarm_ring stays high without an ack.
- ALARM_W, 10, width of the alarm minutes field (max 1023 min).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sec_tick  in  1  one-cycle pulse per elapsed second from the timekeeping core
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_mode  in  3  1=12h display, 2=24h display, 3=set time/date, 4=arm alarm, 0/5-7 illegal
- cmd_hour  in  5  set hour
- cmd_min  in  6  set minute
- cmd_sec  in  6  set second
- cmd_day  in  5  set day
- cmd_month  in  4  set month
- cmd_year  in  12  set year
- cmd_alarm_min  in  ALARM_W  alarm delay in minutes
- cur_hour  in  5  live hour from the core, 0-23
- load  out  1  one-cycle strobe; the core captures set_* on it
- set_hour/set_min/set_sec/set_day/set_month/set_year  out  5/6/6/5/4/12  registered set bus
- cmd_err  out  1  one-cycle pulse when a command is rejected
- fmt_12h  out  1  1 = 12 h display mode
- disp_hour  out  5  hour to display: 1-12 in 12 h mode, 0-23 in 24 h mode
- pm  out  1  1 when cur_hour >= 12; forced 0 in 24 h mode
- alarm_armed  out  1  countdown active
- alarm_ring  out  1  alarm sounding
- alarm_ack  in  1  silences the ring

Behaviour:
- Reset values:
  - fmt_12h=0, load=0, cmd_err=0, alarm_armed=0, alarm_ring=0, disp_hour=0, pm=0.
  - set_* = 0:0:0, day 1, month 1, year YEAR_MIN.
  - FSM=IDLE; countdown counter = 0; ring counter = 0.
- FSM states: IDLE, CHECK, LOAD, ERR.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture all cmd_* fields into holding registers and go to CHECK.
  - A transfer happens on cmd_valid & cmd_ready only.
- CHECK (cmd_ready=0, 1 cycle):
  - Mode 1: set fmt_12h=1, go to IDLE.
  - Mode 2: clear fmt_12h, go to IDLE.
  - Mode 3: go to LOAD if hour<24, min<60, sec<60, 1<=month<=12, 1<=day<=days_in_month(month,year), and YEAR_MIN<=year<=YEAR_MAX; otherwise go to ERR.
  - Mode 4:
    - If alarm_min==0, go to ERR.
    - Otherwise load countdown = alarm_min*60 (16-bit, no overflow at 1023), set alarm_armed=1, clear alarm_ring, go to IDLE.
  - Illegal mode: go to ERR.
- LOAD: drive set_* from the holding registers and assert load for exactly 1 cycle, then go to IDLE. set_* holds its value after load.
- ERR: cmd_err=1 for 1 cycle, no state change elsewhere, then go to IDLE.
- Command latency: accept to load = 2 cycles; accept to cmd_ready re-high = 2 cycles for modes 1/2/4, 3 cycles for mode 3 and errors.
leap year: divisible by 4 and not by 100, or divisible by 400.
- Alarm countdown:
  - While alarm_armed, each sec_tick decrements the counter.
  - On the tick that takes the counter from 1 to 0: clear alarm_armed, set alarm_ring, load ring counter = RING_SECS.
- Alarm ring:
  - While ringing, each sec_tick decrements the ring counter.
  - Clear alarm_ring when it reaches 0, or on alarm_ack (ack has priority, same cycle).
  - alarm_ack while not ringing is ignored.
- Re-arm with mode 4 while armed or ringing: the countdown restarts from the new value and the ring clears.
- Simultaneous events:
  - sec_tick in the same cycle as re-arm: the re-arm wins and that tick is not counted.
  - A mode-3 load does not affect the alarm countdown.
- Display (registered, 1-cycle latency from cur_hour):
  - 12 h mode: disp_hour = 12 if cur_hour==0, cur_hour-12 if cur_hour>12, else cur_hour; pm = (cur_hour>=12).
  - 24 h mode: disp_hour = cur_hour; pm = 0.
- Asynchronous reset mid-command aborts: no load or err pulse is issued, and the alarm is disarmed.

Decomposition:
- Package clock_pkg:
  - mode encodings (MODE_12H=1, MODE_24H=2, MODE_SET=3, MODE_ALARM=4)
  - FSM state enum
  - days_in_month(month, year) function with leap rule
  - YEAR_MIN/YEAR_MAX defaults
- Sub-module alarm_timer holds the countdown and ring counters. Its interface:
  - inputs arm, arm_secs, sec_tick, ack
  - outputs armed, ring
- The command FSM and display formatting stay in the top level.

Test Plan:
- Reset, then mode 3 with 23:59:58, 29/2/2024 -> load pulses exactly 2 cycles after accept; set_* equals the inputs; cmd_err stays 0.
- Mode 3 with 29/2/2023, then 31/4/2024, then hour=24, then year=2026 -> four cmd_err pulses, no load, set_* unchanged.
- Mode 1, then sweep cur_hour 0, 1, 12, 13, 23 -> disp_hour/pm = 12/0, 1/0, 12/1, 1/1, 11/1; mode 2 with cur_hour=13 -> 13/0.
- Mode 4 with alarm_min=1, 60 sec_ticks -> alarm_armed drops and alarm_ring rises on tick 60; 30 more ticks -> ring clears.
- Ringing, alarm_ack asserted together with sec_tick -> ring clears the next cycle; re-arm with 2 during an active countdown -> ring occurs 120 ticks after the re-arm.
- Mode 4 with 0, and mode 6 -> cmd_err pulse each; assert reset during CHECK of a valid mode 3 -> no load, all outputs at reset values.
